// File: rtl/dm_ndmreset_pkg.sv
// Shared types and defaults for the debug-module ndmreset sequencer.
package dm_ndmreset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } ndm_state_e;

  localparam int MinAssertCyclesDefault = 16;
  localparam int AckTimeoutDefault      = 1024;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int cnt_width(input int min_assert, input int ack_timeout);
    int max_val;
    max_val = (min_assert > ack_timeout) ? min_assert : ack_timeout;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dm_ndmreset_seq_if.sv
// dmcontrol-side requests and system-side reset/status pins of the ndmreset sequencer.
interface dm_ndmreset_seq_if #(
  parameter int NrHarts = 1
);
  logic               testmode_i;
  logic               dmactive_req_i;
  logic               ndmreset_req_i;
  logic [NrHarts-1:0] hart_rst_done_i;
  logic [NrHarts-1:0] ackhavereset_i;
  logic               ndmreset_o;
  logic               dmactive_o;
  logic [NrHarts-1:0] havereset_o;
  logic               busy_o;
  logic               timeout_o;

  modport master (
    output testmode_i, dmactive_req_i, ndmreset_req_i, hart_rst_done_i, ackhavereset_i,
    input  ndmreset_o, dmactive_o, havereset_o, busy_o, timeout_o
  );

  modport slave (
    input  testmode_i, dmactive_req_i, ndmreset_req_i, hart_rst_done_i, ackhavereset_i,
    output ndmreset_o, dmactive_o, havereset_o, busy_o, timeout_o
  );
endinterface

// File: rtl/dm_ndmreset_seq.sv
// Sequences ndmreset/dmactive: stretched reset pulse, then a bounded wait for all
// harts to ack, tracking sticky per-hart havereset flags.
module dm_ndmreset_seq
  import dm_ndmreset_pkg::*;
#(
  parameter int NrHarts         = 1,
  parameter int MinAssertCycles = MinAssertCyclesDefault,
  parameter int AckTimeout      = AckTimeoutDefault
) (
  input logic            clk_i,
  input logic            rst_i,
  dm_ndmreset_seq_if.slave bus
);

  localparam int CntW = cnt_width(MinAssertCycles, AckTimeout);
  localparam logic [CntW-1:0] AssertLast = CntW'(MinAssertCycles - 1);
  localparam logic [CntW-1:0] AssertSat  = CntW'(MinAssertCycles);
  localparam logic [CntW-1:0] AckLast    = CntW'(AckTimeout - 1);

  ndm_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic               ndmreset_q;
  logic               dmactive_q;
  logic               busy_q;
  logic               timeout_q;
  logic [NrHarts-1:0] havereset_q;
  logic               all_done;

  assign all_done = &bus.hart_rst_done_i;

  // NOTE: state is updated with <= only, so every branch reads the pre-edge values
  // and the order of assignments inside one block is irrelevant except where noted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ndmreset_q  <= 1'b0;
      dmactive_q  <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      havereset_q <= '1;
    end else begin
      dmactive_q <= bus.dmactive_req_i;
      if (!dmactive_q) begin
        // Inactive DM aborts any sequence; havereset is frozen.
        state_q    <= IDLE;
        cnt_q      <= '0;
        ndmreset_q <= 1'b0;
        busy_q     <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        havereset_q <= havereset_q & ~bus.ackhavereset_i;
        unique case (state_q)
          IDLE: begin
            if (bus.ndmreset_req_i && !bus.testmode_i) begin
              state_q    <= ASSERT;
              cnt_q      <= '0;
              ndmreset_q <= 1'b1;
              busy_q     <= 1'b1;
              timeout_q  <= 1'b0;
            end
          end
          ASSERT: begin
            if (cnt_q != AssertSat) cnt_q <= cnt_q + CntW'(1);
            if (cnt_q >= AssertLast && !bus.ndmreset_req_i) begin
              state_q    <= RELEASE;
              cnt_q      <= '0;
              ndmreset_q <= 1'b0;
            end
          end
          RELEASE: begin
            cnt_q <= cnt_q + CntW'(1);
            if (all_done || cnt_q == AckLast) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              timeout_q <= !all_done;
              // NOTE: this later assignment overrides the ack-clear above, so a
              // set and clear of the same bit in one cycle leaves it set.
              havereset_q <= '1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Test mode masks the system reset after the register; the sequence itself runs on.
  assign bus.ndmreset_o  = ndmreset_q & ~bus.testmode_i;
  assign bus.dmactive_o  = dmactive_q;
  assign bus.havereset_o = havereset_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_dm_ndmreset_seq.sv
// Scoreboard bench for dm_ndmreset_seq: each sequence pushes its expected pulse
// length, release length, timeout and havereset; a monitor checks on busy falling.
module tb_dm_ndmreset_seq;

  typedef struct packed {
    logic [31:0] pulse;
    logic [31:0] rel;
    logic        tmo;
    logic [1:0]  hr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  dm_ndmreset_seq_if #(.NrHarts(2)) bus ();

  dm_ndmreset_seq #(
    .NrHarts(2),
    .MinAssertCycles(16),
    .AckTimeout(1024)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measures each sequence and compares it on completion.
  logic        prev_busy = 1'b0;
  logic        prev_ndm  = 1'b0;
  logic [31:0] pulse_cnt = 0;
  logic [31:0] rel_cnt   = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_ndm  = 1'b0;
      pulse_cnt = 0;
      rel_cnt   = 0;
    end else begin
      if (bus.ndmreset_o) begin
        if (!prev_ndm) begin
          pulse_cnt = 0;
          rel_cnt   = 0;
        end
        pulse_cnt++;
      end else if (bus.busy_o) begin
        rel_cnt++;
      end
      if (prev_busy && !bus.busy_o) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("seq_pulse_len", pulse_cnt, e.pulse);
          check("seq_release_len", rel_cnt, e.rel);
          check("seq_timeout", {31'd0, bus.timeout_o}, {31'd0, e.tmo});
          check("seq_havereset", {30'd0, bus.havereset_o}, {30'd0, e.hr});
        end
      end
      prev_busy = bus.busy_o;
      prev_ndm  = bus.ndmreset_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int req_cycles);
    tick();
    bus.ndmreset_req_i = 1'b1;
    repeat (req_cycles) @(posedge clk);
    #1;
    bus.ndmreset_req_i = 1'b0;
  endtask

  task automatic wait_ndm_low(input int budget);
    int n = 0;
    while (bus.ndmreset_o && n < budget) begin
      tick();
      n++;
    end
    check("ndm_low_within_budget", {31'd0, bus.ndmreset_o}, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy_o && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", {31'd0, bus.busy_o}, 32'd0);
  endtask

  // ack_delay: cycles after ndmreset falls before harts ack; collide pulses
  // ackhavereset on the completion edge.
  task automatic run_seq(input int req_cycles, input int ack_delay, input logic collide);
    issue(req_cycles);
    wait_ndm_low(100);
    repeat (ack_delay) tick();
    bus.hart_rst_done_i = 2'b11;
    bus.ackhavereset_i  = collide ? 2'b11 : 2'b00;
    tick();
    bus.ackhavereset_i  = 2'b00;
    wait_idle(10);
    bus.hart_rst_done_i = 2'b00;
  endtask

  task automatic ack_pulse(input logic [1:0] v, input logic [1:0] exp_hr, input string name);
    tick();
    bus.ackhavereset_i = v;
    tick();
    bus.ackhavereset_i = 2'b00;
    check(name, {30'd0, bus.havereset_o}, {30'd0, exp_hr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.testmode_i      = 1'b0;
    bus.dmactive_req_i  = 1'b0;
    bus.ndmreset_req_i  = 1'b0;
    bus.hart_rst_done_i = 2'b00;
    bus.ackhavereset_i  = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    check("rst_ndmreset", {31'd0, bus.ndmreset_o}, 32'd0);
    check("rst_dmactive", {31'd0, bus.dmactive_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout_o}, 32'd0);
    check("rst_havereset", {30'd0, bus.havereset_o}, 32'd3);

    bus.dmactive_req_i = 1'b1;
    #1 check("dmactive_not_yet", {31'd0, bus.dmactive_o}, 32'd0);
    tick();
    check("dmactive_one_cycle", {31'd0, bus.dmactive_o}, 32'd1);

    ack_pulse(2'b01, 2'b10, "ack_bit0");
    ack_pulse(2'b10, 2'b00, "ack_bit1");

    // Short request: 16-cycle stretched pulse, ack three release cycles in.
    sb.push_back('{pulse: 16, rel: 3, tmo: 1'b0, hr: 2'b11});
    run_seq(1, 2, 1'b0);
    ack_pulse(2'b11, 2'b00, "ack_after_short");

    // Long request: pulse follows the 40-cycle request.
    sb.push_back('{pulse: 40, rel: 1, tmo: 1'b0, hr: 2'b11});
    run_seq(40, 0, 1'b0);
    ack_pulse(2'b11, 2'b00, "ack_after_long");

    // Timeout: only one of two harts ever acks.
    bus.hart_rst_done_i = 2'b01;
    sb.push_back('{pulse: 16, rel: 1024, tmo: 1'b1, hr: 2'b11});
    issue(1);
    wait_idle(1100);
    bus.hart_rst_done_i = 2'b00;
    check("timeout_sticky", {31'd0, bus.timeout_o}, 32'd1);
    ack_pulse(2'b11, 2'b00, "ack_after_timeout");

    // Good sequence clears timeout; ack collides with the completion set.
    sb.push_back('{pulse: 16, rel: 1, tmo: 1'b0, hr: 2'b11});
    run_seq(1, 0, 1'b1);
    ack_pulse(2'b01, 2'b10, "ack_before_abort");

    // Abort: dmactive dropped five cycles into ASSERT.
    sb.push_back('{pulse: 7, rel: 0, tmo: 1'b0, hr: 2'b10});
    issue(1);
    repeat (5) tick();
    bus.dmactive_req_i = 1'b0;
    tick();
    check("abort_dmactive_low", {31'd0, bus.dmactive_o}, 32'd0);
    check("abort_ndm_still_high", {31'd0, bus.ndmreset_o}, 32'd1);
    tick();
    check("abort_ndm_low", {31'd0, bus.ndmreset_o}, 32'd0);
    check("abort_idle", {31'd0, bus.busy_o}, 32'd0);
    ack_pulse(2'b10, 2'b10, "havereset_held_inactive");
    bus.dmactive_req_i = 1'b1;
    tick();
    check("dmactive_restored", {31'd0, bus.dmactive_o}, 32'd1);

    // Test mode: requests are refused in IDLE.
    bus.testmode_i     = 1'b1;
    bus.ndmreset_req_i = 1'b1;
    repeat (5) tick();
    check("tm_ndm_low", {31'd0, bus.ndmreset_o}, 32'd0);
    check("tm_stays_idle", {31'd0, bus.busy_o}, 32'd0);
    bus.ndmreset_req_i = 1'b0;
    bus.testmode_i     = 1'b0;
    tick();
    check("tm_exit_idle", {31'd0, bus.busy_o}, 32'd0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
